// File: rtl/mc_pkg.sv
// -----------------------------------------------------------------------------
// mc_pkg
// Shared definitions for the multi-cycle RV32I-subset control unit:
//   - state encoding of the control FSM
//   - opcode / funct3 / funct7 constants of the supported instructions
//   - ALU operation, PC source and write-back source select codes
//   - instruction class enum produced by mc_decode
//   - branch condition helper
// No ports (package).
// -----------------------------------------------------------------------------
package mc_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_HALT   = 3'd7
  } state_t;

  typedef enum logic [3:0] {
    CLS_ILLEGAL,
    CLS_LUI,
    CLS_JAL,
    CLS_JALR,
    CLS_BRANCH,
    CLS_LOAD,
    CLS_STORE,
    CLS_ALUI,
    CLS_ALUR
  } ins_class_t;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  localparam logic [2:0] F3_JALR = 3'b000;
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_LW   = 3'b010;
  localparam logic [2:0] F3_SW   = 3'b010;
  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_OR   = 3'b110;

  localparam logic [6:0] F7_BASE = 7'b0000000;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_XOR = 3'd2;
  localparam logic [2:0] ALU_OR  = 3'd3;
  localparam logic [2:0] ALU_SLL = 3'd4;

  localparam logic [1:0] PC_PLUS4 = 2'd0;
  localparam logic [1:0] PC_IMM   = 2'd1;
  localparam logic [1:0] PC_ALU   = 2'd2;

  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MEM = 2'd1;
  localparam logic [1:0] WB_PC4 = 2'd2;
  localparam logic [1:0] WB_IMM = 2'd3;

  // Only BEQ/BLT/BGE reach this; any other funct3 was already rejected.
  function automatic logic branch_taken(input logic [2:0] funct3,
                                        input logic eq,
                                        input logic lt);
    logic taken;
    taken = 1'b0;
    case (funct3)
      F3_BEQ:  taken = eq;
      F3_BLT:  taken = lt;
      F3_BGE:  taken = ~lt;
      default: taken = 1'b0;
    endcase
    return taken;
  endfunction

endpackage

// File: rtl/mc_decode.sv
// -----------------------------------------------------------------------------
// mc_decode
// Combinational instruction decoder for the control unit.
// Ports:
//   ins       in  32  instruction register contents
//   cls       out     instruction class (CLS_ILLEGAL for unsupported encodings)
//   legal     out 1   instruction is in the supported set
//   alu_op    out 3   ALU operation for this instruction
//   alu_b_sel out 1   ALU operand B: 0 = rs2, 1 = immediate
//   wb_sel    out 2   register write-back source
// -----------------------------------------------------------------------------
module mc_decode
  import mc_pkg::*;
(
  input  logic [31:0] ins,
  output ins_class_t  cls,
  output logic        legal,
  output logic [2:0]  alu_op,
  output logic        alu_b_sel,
  output logic [1:0]  wb_sel
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       unused_ins_fields;

  assign opcode = ins[6:0];
  assign funct3 = ins[14:12];
  assign funct7 = ins[31:25];

  // Register and immediate fields are consumed by the datapath only.
  assign unused_ins_fields = ^{ins[24:15], ins[11:7]};

  // funct7 is checked for R-type and SLLI so SUB/SRA-style encodings halt.
  always_comb begin
    cls       = CLS_ILLEGAL;
    alu_op    = ALU_ADD;
    alu_b_sel = 1'b0;
    wb_sel    = WB_ALU;
    case (opcode)
      OP_LUI: begin
        cls    = CLS_LUI;
        wb_sel = WB_IMM;
      end
      OP_JAL: begin
        cls    = CLS_JAL;
        wb_sel = WB_PC4;
      end
      OP_JALR: begin
        if (funct3 == F3_JALR) begin
          cls       = CLS_JALR;
          alu_b_sel = 1'b1;
          wb_sel    = WB_PC4;
        end
      end
      OP_BRANCH: begin
        if (funct3 == F3_BEQ || funct3 == F3_BLT || funct3 == F3_BGE) begin
          cls = CLS_BRANCH;
        end
      end
      OP_LOAD: begin
        if (funct3 == F3_LW) begin
          cls       = CLS_LOAD;
          alu_b_sel = 1'b1;
          wb_sel    = WB_MEM;
        end
      end
      OP_STORE: begin
        if (funct3 == F3_SW) begin
          cls       = CLS_STORE;
          alu_b_sel = 1'b1;
        end
      end
      OP_IMM: begin
        alu_b_sel = 1'b1;
        case (funct3)
          F3_ADD: cls = CLS_ALUI;
          F3_XOR: begin
            cls    = CLS_ALUI;
            alu_op = ALU_XOR;
          end
          F3_SLL: begin
            if (funct7 == F7_BASE) begin
              cls    = CLS_ALUI;
              alu_op = ALU_SLL;
            end
          end
          default: cls = CLS_ILLEGAL;
        endcase
      end
      OP_REG: begin
        if (funct7 == F7_BASE) begin
          case (funct3)
            F3_ADD: cls = CLS_ALUR;
            F3_XOR: begin
              cls    = CLS_ALUR;
              alu_op = ALU_XOR;
            end
            F3_OR: begin
              cls    = CLS_ALUR;
              alu_op = ALU_OR;
            end
            default: cls = CLS_ILLEGAL;
          endcase
        end
      end
      default: cls = CLS_ILLEGAL;
    endcase
  end

  assign legal = (cls != CLS_ILLEGAL);

endmodule

// File: rtl/mc_control.sv
// -----------------------------------------------------------------------------
// mc_control
// Multi-cycle control unit for the RV32I-subset core. Sequences the shared
// datapath through FETCH/DECODE/EXEC/MEM/WB with a req/ack memory handshake.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   ins           IR contents
//   mem_ack       memory completes the pending access
//   eq, lt        rs1==rs2, signed rs1<rs2
//   mem_req/mem_we/mem_addr_sel   memory request controls
//   ir_we, pc_we, pc_src          IR / PC update controls
//   reg_we, wb_sel                register write-back controls
//   alu_a_sel, alu_b_sel, alu_op  ALU controls
//   illegal       sticky halt flag
//   state         current FSM state (debug)
//   cycles        saturating cycle counter
//   retired       saturating retired-instruction counter
// -----------------------------------------------------------------------------
module mc_control
  import mc_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      ins,
  input  logic             mem_ack,
  input  logic             eq,
  input  logic             lt,
  output logic             mem_req,
  output logic             mem_we,
  output logic             mem_addr_sel,
  output logic             ir_we,
  output logic             pc_we,
  output logic [1:0]       pc_src,
  output logic             reg_we,
  output logic [1:0]       wb_sel,
  output logic             alu_a_sel,
  output logic             alu_b_sel,
  output logic [2:0]       alu_op,
  output logic             illegal,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] cycles,
  output logic [CNT_W-1:0] retired
);

  state_t     cur_state;
  state_t     next_state;
  ins_class_t cls;
  logic       legal;
  logic [2:0] dec_alu_op;
  logic       dec_alu_b_sel;
  logic [1:0] dec_wb_sel;

  mc_decode u_decode (
    .ins       (ins),
    .cls       (cls),
    .legal     (legal),
    .alu_op    (dec_alu_op),
    .alu_b_sel (dec_alu_b_sel),
    .wb_sel    (dec_wb_sel)
  );

  assign state = cur_state;

  always_ff @(posedge clk) begin
    if (rst) begin
      cur_state <= ST_FETCH;
    end else begin
      cur_state <= next_state;
    end
  end

  always_comb begin
    next_state = cur_state;
    case (cur_state)
      ST_FETCH: begin
        if (mem_ack) next_state = ST_DECODE;
      end
      ST_DECODE: begin
        if (!legal) begin
          next_state = ST_HALT;
        end else if (cls == CLS_LUI || cls == CLS_JAL) begin
          next_state = ST_WB;
        end else begin
          next_state = ST_EXEC;
        end
      end
      ST_EXEC: begin
        case (cls)
          CLS_ALUR, CLS_ALUI:    next_state = ST_WB;
          CLS_LOAD, CLS_STORE:   next_state = ST_MEM;
          CLS_BRANCH, CLS_JALR:  next_state = ST_FETCH;
          default:               next_state = ST_HALT;
        endcase
      end
      ST_MEM: begin
        if (mem_ack) next_state = (cls == CLS_STORE) ? ST_FETCH : ST_WB;
      end
      ST_WB:   next_state = ST_FETCH;
      ST_HALT: next_state = ST_HALT;
      default: next_state = ST_HALT;
    endcase
  end

  // Reset forces every control to 0 combinationally, so a request pending
  // when rst rises is withdrawn in the same cycle.
  always_comb begin
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr_sel = 1'b0;
    ir_we        = 1'b0;
    pc_we        = 1'b0;
    pc_src       = PC_PLUS4;
    reg_we       = 1'b0;
    wb_sel       = WB_ALU;
    alu_a_sel    = 1'b0;
    alu_b_sel    = 1'b0;
    alu_op       = ALU_ADD;
    if (!rst) begin
      case (cur_state)
        ST_FETCH: begin
          mem_req = 1'b1;
          ir_we   = mem_ack;
        end
        ST_EXEC: begin
          alu_op    = dec_alu_op;
          alu_b_sel = dec_alu_b_sel;
          if (cls == CLS_BRANCH) begin
            pc_we  = 1'b1;
            pc_src = branch_taken(ins[14:12], eq, lt) ? PC_IMM : PC_PLUS4;
          end else if (cls == CLS_JALR) begin
            reg_we = 1'b1;
            wb_sel = WB_PC4;
            pc_we  = 1'b1;
            pc_src = PC_ALU;
          end
        end
        ST_MEM: begin
          mem_req      = 1'b1;
          mem_addr_sel = 1'b1;
          mem_we       = (cls == CLS_STORE);
          alu_op       = dec_alu_op;
          alu_b_sel    = dec_alu_b_sel;
          if (cls == CLS_STORE && mem_ack) begin
            pc_we = 1'b1;
          end
        end
        ST_WB: begin
          alu_op    = dec_alu_op;
          alu_b_sel = dec_alu_b_sel;
          reg_we    = 1'b1;
          wb_sel    = dec_wb_sel;
          pc_we     = 1'b1;
          pc_src    = (cls == CLS_JAL) ? PC_IMM : PC_PLUS4;
        end
        default: ;
      endcase
    end
  end

  // pc_we marks the retiring cycle of every instruction.
  always_ff @(posedge clk) begin
    if (rst) begin
      illegal <= 1'b0;
      cycles  <= '0;
      retired <= '0;
    end else begin
      if (next_state == ST_HALT) illegal <= 1'b1;
      if (cycles != '1) cycles <= cycles + CNT_W'(1);
      if (pc_we && retired != '1) retired <= retired + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_mc_control.sv
// -----------------------------------------------------------------------------
// tb_mc_control
// Directed testbench for mc_control: walks a reset, ADDI, LW with wait
// states, BLT/BGE, JAL/JALR, XOR, LUI, an illegal opcode and a reset
// during a pending store, comparing outputs with hand-computed values.
// -----------------------------------------------------------------------------
module tb_mc_control;

  logic        clk;
  logic        rst;
  logic [31:0] ins;
  logic        mem_ack;
  logic        eq;
  logic        lt;
  logic        mem_req;
  logic        mem_we;
  logic        mem_addr_sel;
  logic        ir_we;
  logic        pc_we;
  logic [1:0]  pc_src;
  logic        reg_we;
  logic [1:0]  wb_sel;
  logic        alu_a_sel;
  logic        alu_b_sel;
  logic [2:0]  alu_op;
  logic        illegal;
  logic [2:0]  state;
  logic [31:0] cycles;
  logic [31:0] retired;

  int          total_cnt;
  int          bad_cnt;
  logic [31:0] exp_cycles;

  localparam logic [31:0] I_ADDI = 32'h00500093;
  localparam logic [31:0] I_LW   = 32'h0000A103;
  localparam logic [31:0] I_BLT  = 32'h0020C463;
  localparam logic [31:0] I_BGE  = 32'h0020D463;
  localparam logic [31:0] I_JAL  = 32'h010000EF;
  localparam logic [31:0] I_JALR = 32'h000100E7;
  localparam logic [31:0] I_XOR  = 32'h0020C1B3;
  localparam logic [31:0] I_LUI  = 32'h123452B7;
  localparam logic [31:0] I_BAD  = 32'h0000007F;
  localparam logic [31:0] I_SW   = 32'h0020A223;

  mc_control #(.CNT_W(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .ins          (ins),
    .mem_ack      (mem_ack),
    .eq           (eq),
    .lt           (lt),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_addr_sel (mem_addr_sel),
    .ir_we        (ir_we),
    .pc_we        (pc_we),
    .pc_src       (pc_src),
    .reg_we       (reg_we),
    .wb_sel       (wb_sel),
    .alu_a_sel    (alu_a_sel),
    .alu_b_sel    (alu_b_sel),
    .alu_op       (alu_op),
    .illegal      (illegal),
    .state        (state),
    .cycles       (cycles),
    .retired      (retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
    total_cnt++;
    if (got !== exp) begin
      bad_cnt++;
      $display("[TB] FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Drives one cycle's inputs just after the edge and returns near the
  // falling edge, where the combinational outputs of that cycle are stable.
  task automatic applyStimulus(input logic r, input logic [31:0] i,
                               input logic a, input logic e, input logic l);
    @(posedge clk);
    if (rst) exp_cycles = 32'd0;
    else if (exp_cycles != 32'hFFFF_FFFF) exp_cycles = exp_cycles + 32'd1;
    #1;
    rst     = r;
    ins     = i;
    mem_ack = a;
    eq      = e;
    lt      = l;
    #4;
  endtask

  task automatic stepCheck(input logic r, input logic [31:0] i, input logic a,
                           input logic e, input logic l,
                           input logic [2:0] exp_state, input string tag);
    applyStimulus(r, i, a, e, l);
    checkOutput({tag, "_state"}, {29'd0, state}, {29'd0, exp_state});
    checkOutput({tag, "_cycles"}, cycles, exp_cycles);
  endtask

  initial begin
    total_cnt  = 0;
    bad_cnt    = 0;
    exp_cycles = 32'd0;
    rst        = 1'b1;
    ins        = 32'd0;
    mem_ack    = 1'b0;
    eq         = 1'b0;
    lt         = 1'b0;

    $display("[TB] reset");
    applyStimulus(1'b1, I_ADDI, 1'b0, 1'b0, 1'b0);
    checkOutput("rst_mem_req", {31'd0, mem_req}, 32'd0);
    applyStimulus(1'b1, I_ADDI, 1'b1, 1'b0, 1'b0);
    checkOutput("rst_mem_req_ack", {31'd0, mem_req}, 32'd0);
    checkOutput("rst_ir_we", {31'd0, ir_we}, 32'd0);

    $display("[TB] ADDI");
    stepCheck(1'b0, I_ADDI, 1'b1, 1'b0, 1'b0, 3'd0, "addi_fetch");
    checkOutput("addi_fetch_cycles0", cycles, 32'd0);
    checkOutput("addi_fetch_retired0", retired, 32'd0);
    checkOutput("addi_fetch_illegal", {31'd0, illegal}, 32'd0);
    checkOutput("addi_fetch_mem_req", {31'd0, mem_req}, 32'd1);
    checkOutput("addi_fetch_ir_we", {31'd0, ir_we}, 32'd1);
    checkOutput("addi_fetch_addr_sel", {31'd0, mem_addr_sel}, 32'd0);
    stepCheck(1'b0, I_ADDI, 1'b0, 1'b0, 1'b0, 3'd1, "addi_decode");
    checkOutput("addi_decode_reg_we", {31'd0, reg_we}, 32'd0);
    stepCheck(1'b0, I_ADDI, 1'b0, 1'b0, 1'b0, 3'd2, "addi_exec");
    checkOutput("addi_exec_reg_we", {31'd0, reg_we}, 32'd0);
    checkOutput("addi_exec_pc_we", {31'd0, pc_we}, 32'd0);
    checkOutput("addi_exec_b_sel", {31'd0, alu_b_sel}, 32'd1);
    stepCheck(1'b0, I_ADDI, 1'b0, 1'b0, 1'b0, 3'd4, "addi_wb");
    checkOutput("addi_wb_reg_we", {31'd0, reg_we}, 32'd1);
    checkOutput("addi_wb_wb_sel", {30'd0, wb_sel}, 32'd0);
    checkOutput("addi_wb_alu_op", {29'd0, alu_op}, 32'd0);
    checkOutput("addi_wb_b_sel", {31'd0, alu_b_sel}, 32'd1);
    checkOutput("addi_wb_pc_we", {31'd0, pc_we}, 32'd1);
    checkOutput("addi_wb_pc_src", {30'd0, pc_src}, 32'd0);

    $display("[TB] LW with 3 wait cycles in FETCH and MEM");
    for (int k = 0; k < 4; k++) begin
      stepCheck(1'b0, I_LW, (k == 3), 1'b0, 1'b0, 3'd0, "lw_fetch");
      checkOutput("lw_fetch_ir_we", {31'd0, ir_we}, (k == 3) ? 32'd1 : 32'd0);
      if (k == 0) begin
        checkOutput("lw_start_retired", retired, 32'd1);
        checkOutput("lw_start_cycles", cycles, 32'd4);
      end
    end
    stepCheck(1'b0, I_LW, 1'b0, 1'b0, 1'b0, 3'd1, "lw_decode");
    stepCheck(1'b0, I_LW, 1'b0, 1'b0, 1'b0, 3'd2, "lw_exec");
    checkOutput("lw_exec_b_sel", {31'd0, alu_b_sel}, 32'd1);
    for (int k = 0; k < 4; k++) begin
      stepCheck(1'b0, I_LW, (k == 3), 1'b0, 1'b0, 3'd3, "lw_mem");
      checkOutput("lw_mem_req", {31'd0, mem_req}, 32'd1);
      checkOutput("lw_mem_addr_sel", {31'd0, mem_addr_sel}, 32'd1);
      checkOutput("lw_mem_we", {31'd0, mem_we}, 32'd0);
      checkOutput("lw_mem_pc_we", {31'd0, pc_we}, 32'd0);
    end
    stepCheck(1'b0, I_LW, 1'b0, 1'b0, 1'b0, 3'd4, "lw_wb");
    checkOutput("lw_wb_wb_sel", {30'd0, wb_sel}, 32'd1);
    checkOutput("lw_wb_reg_we", {31'd0, reg_we}, 32'd1);

    $display("[TB] BLT taken, BGE not taken");
    stepCheck(1'b0, I_BLT, 1'b1, 1'b0, 1'b1, 3'd0, "blt_fetch");
    checkOutput("blt_start_retired", retired, 32'd2);
    checkOutput("blt_start_cycles", cycles, 32'd15);
    stepCheck(1'b0, I_BLT, 1'b0, 1'b0, 1'b1, 3'd1, "blt_decode");
    stepCheck(1'b0, I_BLT, 1'b0, 1'b0, 1'b1, 3'd2, "blt_exec");
    checkOutput("blt_pc_we", {31'd0, pc_we}, 32'd1);
    checkOutput("blt_pc_src", {30'd0, pc_src}, 32'd1);
    checkOutput("blt_reg_we", {31'd0, reg_we}, 32'd0);
    stepCheck(1'b0, I_BGE, 1'b1, 1'b0, 1'b1, 3'd0, "bge_fetch");
    checkOutput("bge_start_retired", retired, 32'd3);
    checkOutput("bge_start_cycles", cycles, 32'd18);
    stepCheck(1'b0, I_BGE, 1'b0, 1'b0, 1'b1, 3'd1, "bge_decode");
    stepCheck(1'b0, I_BGE, 1'b0, 1'b0, 1'b1, 3'd2, "bge_exec");
    checkOutput("bge_pc_we", {31'd0, pc_we}, 32'd1);
    checkOutput("bge_pc_src", {30'd0, pc_src}, 32'd0);
    checkOutput("bge_reg_we", {31'd0, reg_we}, 32'd0);

    $display("[TB] JAL, JALR");
    stepCheck(1'b0, I_JAL, 1'b1, 1'b0, 1'b0, 3'd0, "jal_fetch");
    checkOutput("jal_start_retired", retired, 32'd4);
    checkOutput("jal_start_cycles", cycles, 32'd21);
    stepCheck(1'b0, I_JAL, 1'b0, 1'b0, 1'b0, 3'd1, "jal_decode");
    stepCheck(1'b0, I_JAL, 1'b0, 1'b0, 1'b0, 3'd4, "jal_wb");
    checkOutput("jal_reg_we", {31'd0, reg_we}, 32'd1);
    checkOutput("jal_wb_sel", {30'd0, wb_sel}, 32'd2);
    checkOutput("jal_pc_src", {30'd0, pc_src}, 32'd1);
    checkOutput("jal_pc_we", {31'd0, pc_we}, 32'd1);
    stepCheck(1'b0, I_JALR, 1'b1, 1'b0, 1'b0, 3'd0, "jalr_fetch");
    checkOutput("jalr_start_retired", retired, 32'd5);
    checkOutput("jalr_start_cycles", cycles, 32'd24);
    stepCheck(1'b0, I_JALR, 1'b0, 1'b0, 1'b0, 3'd1, "jalr_decode");
    stepCheck(1'b0, I_JALR, 1'b0, 1'b0, 1'b0, 3'd2, "jalr_exec");
    checkOutput("jalr_reg_we", {31'd0, reg_we}, 32'd1);
    checkOutput("jalr_wb_sel", {30'd0, wb_sel}, 32'd2);
    checkOutput("jalr_pc_src", {30'd0, pc_src}, 32'd2);
    checkOutput("jalr_pc_we", {31'd0, pc_we}, 32'd1);
    checkOutput("jalr_b_sel", {31'd0, alu_b_sel}, 32'd1);

    $display("[TB] XOR, LUI");
    stepCheck(1'b0, I_XOR, 1'b1, 1'b0, 1'b0, 3'd0, "xor_fetch");
    checkOutput("xor_start_retired", retired, 32'd6);
    checkOutput("xor_start_cycles", cycles, 32'd27);
    stepCheck(1'b0, I_XOR, 1'b0, 1'b0, 1'b0, 3'd1, "xor_decode");
    stepCheck(1'b0, I_XOR, 1'b0, 1'b0, 1'b0, 3'd2, "xor_exec");
    checkOutput("xor_alu_op", {29'd0, alu_op}, 32'd2);
    checkOutput("xor_b_sel", {31'd0, alu_b_sel}, 32'd0);
    stepCheck(1'b0, I_XOR, 1'b0, 1'b0, 1'b0, 3'd4, "xor_wb");
    checkOutput("xor_wb_sel", {30'd0, wb_sel}, 32'd0);
    stepCheck(1'b0, I_LUI, 1'b1, 1'b0, 1'b0, 3'd0, "lui_fetch");
    checkOutput("lui_start_retired", retired, 32'd7);
    checkOutput("lui_start_cycles", cycles, 32'd31);
    stepCheck(1'b0, I_LUI, 1'b0, 1'b0, 1'b0, 3'd1, "lui_decode");
    stepCheck(1'b0, I_LUI, 1'b0, 1'b0, 1'b0, 3'd4, "lui_wb");
    checkOutput("lui_wb_sel", {30'd0, wb_sel}, 32'd3);
    checkOutput("lui_reg_we", {31'd0, reg_we}, 32'd1);
    checkOutput("lui_pc_src", {30'd0, pc_src}, 32'd0);

    $display("[TB] illegal opcode");
    stepCheck(1'b0, I_BAD, 1'b1, 1'b0, 1'b0, 3'd0, "bad_fetch");
    checkOutput("bad_start_retired", retired, 32'd8);
    stepCheck(1'b0, I_BAD, 1'b0, 1'b0, 1'b0, 3'd1, "bad_decode");
    checkOutput("bad_decode_illegal", {31'd0, illegal}, 32'd0);
    for (int k = 0; k < 3; k++) begin
      stepCheck(1'b0, I_BAD, k[0], 1'b0, 1'b0, 3'd7, "halt");
      checkOutput("halt_illegal", {31'd0, illegal}, 32'd1);
      checkOutput("halt_mem_req", {31'd0, mem_req}, 32'd0);
      checkOutput("halt_pc_we", {31'd0, pc_we}, 32'd0);
      checkOutput("halt_reg_we", {31'd0, reg_we}, 32'd0);
      checkOutput("halt_retired", retired, 32'd8);
    end
    checkOutput("halt_cycles_end", cycles, 32'd38);
    applyStimulus(1'b1, I_BAD, 1'b0, 1'b0, 1'b0);
    checkOutput("halt_rst_mem_req", {31'd0, mem_req}, 32'd0);

    $display("[TB] reset during SW memory wait");
    stepCheck(1'b0, I_SW, 1'b1, 1'b0, 1'b0, 3'd0, "sw_fetch");
    checkOutput("sw_fetch_illegal", {31'd0, illegal}, 32'd0);
    checkOutput("sw_fetch_retired", retired, 32'd0);
    checkOutput("sw_fetch_cycles", cycles, 32'd0);
    stepCheck(1'b0, I_SW, 1'b0, 1'b0, 1'b0, 3'd1, "sw_decode");
    stepCheck(1'b0, I_SW, 1'b0, 1'b0, 1'b0, 3'd2, "sw_exec");
    stepCheck(1'b0, I_SW, 1'b0, 1'b0, 1'b0, 3'd3, "sw_mem");
    checkOutput("sw_mem_req", {31'd0, mem_req}, 32'd1);
    checkOutput("sw_mem_we", {31'd0, mem_we}, 32'd1);
    checkOutput("sw_mem_addr_sel", {31'd0, mem_addr_sel}, 32'd1);
    applyStimulus(1'b1, I_SW, 1'b0, 1'b0, 1'b0);
    checkOutput("sw_rst_state", {29'd0, state}, 32'd3);
    checkOutput("sw_rst_mem_req", {31'd0, mem_req}, 32'd0);
    checkOutput("sw_rst_mem_we", {31'd0, mem_we}, 32'd0);
    checkOutput("sw_rst_pc_we", {31'd0, pc_we}, 32'd0);
    applyStimulus(1'b1, I_SW, 1'b1, 1'b0, 1'b0);
    checkOutput("late_ack_state", {29'd0, state}, 32'd0);
    checkOutput("late_ack_mem_req", {31'd0, mem_req}, 32'd0);
    checkOutput("late_ack_ir_we", {31'd0, ir_we}, 32'd0);
    checkOutput("late_ack_pc_we", {31'd0, pc_we}, 32'd0);
    stepCheck(1'b0, I_SW, 1'b0, 1'b0, 1'b0, 3'd0, "post_rst");
    checkOutput("post_rst_retired", retired, 32'd0);
    checkOutput("post_rst_cycles0", cycles, 32'd0);
    checkOutput("post_rst_mem_req", {31'd0, mem_req}, 32'd1);
    checkOutput("post_rst_ir_we", {31'd0, ir_we}, 32'd0);
    stepCheck(1'b0, I_SW, 1'b0, 1'b0, 1'b0, 3'd0, "post_rst_wait");
    checkOutput("post_rst_cycles1", cycles, 32'd1);

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
